rr_decoder_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 2-to-4 select decoder among 4 requesters.

---
 rtl/rr_decoder_arbiter.sv | 114 +++++++++++
 tb/tb_rr_decoder_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin arbiter driving a shared 2-to-4 select decoder
// Optional MAX_HOLD grant revocation is compiled in with `define ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;

  // First requester found scanning ptr, ptr+1, ... (mod 4); lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    winner = rr_pick(req, ptr);
  end

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (MAX_HOLD >> HOLD_W) != 0) begin : g_bad_cfg
    $error("rr_decoder_arbiter: MAX_HOLD must be 1..255 and fit in HOLD_W bits");
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
      ptr     <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold    <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (en && |req) begin
            state   <= S_GRANT;
            gnt     <= 4'b0001 << winner;
            gnt_idx <= winner;
            gnt_vld <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold    <= HOLD_W'(1);
`endif
          end
        end
        S_GRANT: begin
          // Disable wins over release and timeout and leaves ptr untouched.
          if (!en) begin
            state   <= S_IDLE;
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
          end else if (!req[gnt_idx]) begin
            state   <= S_RECOVER;
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 2'd1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold == HOLD_W'(MAX_HOLD)) begin
            state   <= S_RECOVER;
            gnt     <= 4'b0000;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 2'd1;
            timeout <= 1'b1;
          end else begin
            hold    <= hold + HOLD_W'(1);
          end
`endif
        end
        S_RECOVER: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          gnt     <= 4'b0000;
          gnt_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_rr_decoder_arbiter;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MH), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference: owner as an integer (-1 = nobody), pointer as an integer mod 4.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_last  = 0;
  bit m_rec   = 1'b0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [3:0] q);
    int c;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_rec = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_rec) begin
        m_rec = 1'b0;
      end else if (m_owner < 0) begin
        if (e && q != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (q[c]) begin
              m_owner = c; m_last = c; m_hold = 1;
              break;
            end
          end
        end
      end else if (!e) begin
        m_owner = -1;
      end else if (!q[m_owner]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_rec = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == MH) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_rec = 1'b1; m_to = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] q);
    logic [3:0] eg;
    rst_n = r; en = e; req = q;
    @(posedge clk);
    model_update(r, e, q);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check("gnt", 32'(gnt), 32'(eg));
    check("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    check("gnt_idx", 32'(gnt_idx), 32'(m_last));
    check("timeout", 32'(timeout), 32'(m_to));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] q;
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
  } vec_t;

  vec_t vecs[29];
  int   to_at;
  logic [3:0] rq;

  initial begin
    // Reset, round-robin 0..3, wrap with 1001, enable abort, reset mid-grant, 1010 tie-break.
    vecs[0]  = '{1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'hF, 4'b0001, 1'b1, 2'd0};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 4'b0001, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 4'hE, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 4'hD, 4'b0000, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 4'b0100, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 1'b1, 4'hB, 4'b0000, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 1'b1, 4'h9, 4'b0000, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 1'b1, 4'h9, 4'b1000, 1'b1, 2'd3};
    vecs[13] = '{1'b1, 1'b1, 4'h1, 4'b0000, 1'b0, 2'd3};
    vecs[14] = '{1'b1, 1'b1, 4'h9, 4'b0000, 1'b0, 2'd3};
    vecs[15] = '{1'b1, 1'b1, 4'h9, 4'b0001, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 1'b1, 4'h8, 4'b0000, 1'b0, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 4'h9, 4'b0000, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 1'b1, 4'h9, 4'b1000, 1'b1, 2'd3};
    vecs[19] = '{1'b1, 1'b0, 4'h9, 4'b0000, 1'b0, 2'd3};
    vecs[20] = '{1'b1, 1'b0, 4'h4, 4'b0000, 1'b0, 2'd3};
    vecs[21] = '{1'b1, 1'b1, 4'h4, 4'b0100, 1'b1, 2'd2};
    vecs[22] = '{1'b1, 1'b0, 4'h4, 4'b0000, 1'b0, 2'd2};
    vecs[23] = '{1'b1, 1'b1, 4'h4, 4'b0100, 1'b1, 2'd2};
    vecs[24] = '{1'b0, 1'b1, 4'h4, 4'b0000, 1'b0, 2'd0};
    vecs[25] = '{1'b1, 1'b1, 4'hA, 4'b0010, 1'b1, 2'd1};
    vecs[26] = '{1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 2'd1};
    vecs[27] = '{1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 2'd1};
    vecs[28] = '{1'b1, 1'b1, 4'h0, 4'b0000, 1'b0, 2'd1};

    rst_n = 1'b0; en = 1'b0; req = 4'h0;
    #1;
    for (int n = 0; n < 29; n++) begin
      step(vecs[n].r, vecs[n].e, vecs[n].q);
      check($sformatf("vec%0d_gnt", n), 32'(gnt), 32'(vecs[n].g));
      check($sformatf("vec%0d_vld", n), 32'(gnt_vld), 32'(vecs[n].v));
      check($sformatf("vec%0d_idx", n), 32'(gnt_idx), 32'(vecs[n].i));
      check($sformatf("vec%0d_to", n), 32'(timeout), 32'd0);
    end

    // No pre-emption: owner 1 keeps the grant while 0 and 3 wait.
    step(1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 4'b0010);
    check("t5_first_gnt", 32'(gnt), 32'h2);
    to_at = -1;
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b1, 4'b1011);
      if (timeout === 1'b1 && to_at < 0) to_at = n;
    end
`ifdef ARB_TIMEOUT_EN
    check("t5_timeout_step", 32'(to_at), 32'd8);
`else
    check("t5_held_gnt", 32'(gnt), 32'h2);
    check("t5_no_timeout", 32'(to_at), 32'hFFFFFFFF);
`endif

`ifdef ARB_TIMEOUT_EN
    // After the revoke: RECOVER, IDLE, then requester 3 wins from ptr=2.
    step(1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 4'b0010);
    for (int n = 1; n <= 7; n++) step(1'b1, 1'b1, 4'b1011);
    check("t5_gnt_before_to", 32'(gnt), 32'h2);
    step(1'b1, 1'b1, 4'b1011);
    check("t5_to_pulse", 32'(timeout), 32'd1);
    check("t5_to_gnt", 32'(gnt), 32'h0);
    step(1'b1, 1'b1, 4'b1011);
    check("t5_to_cleared", 32'(timeout), 32'd0);
    step(1'b1, 1'b1, 4'b1011);
    check("t5_next_owner", 32'(gnt), 32'h8);
`endif

    // Single requester release and immediate reassert: regrant only after RECOVER + IDLE.
    step(1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 4'b0100);
    check("t6_gnt", 32'(gnt), 32'h4);
    step(1'b1, 1'b1, 4'b0000);
    check("t6_release", 32'(gnt), 32'h0);
    step(1'b1, 1'b1, 4'b0100);
    check("t6_recover", 32'(gnt), 32'h0);
    step(1'b1, 1'b1, 4'b0100);
    check("t6_regrant", 32'(gnt), 32'h4);

    // Random run: sticky requests so long holds (and timeouts, if built in) occur.
    rq = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
